// File: rtl/vram_arb_pkg.sv
// Shared types and default widths for the VRAM arbiter slice.
package vram_arb_pkg;

    localparam int DEF_ADDR_W        = 15;
    localparam int DEF_DATA_W        = 8;
    localparam int DEF_HOST_MAX_WAIT = 8;

    // Which requester owns a RAM slot; also the tag carried down the pipeline.
    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_VID  = 2'd1,
        GNT_CPU  = 2'd2,
        GNT_HOST = 2'd3
    } grant_t;

    // Width of a saturating counter that must reach max_val (never below 1 bit).
    function automatic int cnt_width(input int max_val);
        int w;
        w = $clog2(max_val + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/vram_arbiter_if.sv
// Bus bundle between the requesters, the arbiter and the screen RAM.
interface vram_arbiter_if #(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 8
) ();

    // Handshakes: vid_req is a one-cycle pulse answered by vid_valid exactly two
    // cycles later. cpu_req/host_req are held (with stable we/addr/wdata) until
    // the matching ack, which lasts one cycle and qualifies the rdata; a req still
    // high in the cycle after ack is a new request.
    logic              vid_req;
    logic [ADDR_W-1:0] vid_addr;
    logic              vid_valid;
    logic [DATA_W-1:0] vid_rdata;

    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_ack;
    logic [DATA_W-1:0] cpu_rdata;

    logic              host_req;
    logic              host_we;
    logic [ADDR_W-1:0] host_addr;
    logic [DATA_W-1:0] host_wdata;
    logic              host_ack;
    logic [DATA_W-1:0] host_rdata;

    logic [ADDR_W-1:0] ram_addr;
    logic              ram_we;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    modport slave (
        input  vid_req, vid_addr,
        output vid_valid, vid_rdata,
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_ack, cpu_rdata,
        input  host_req, host_we, host_addr, host_wdata,
        output host_ack, host_rdata,
        output ram_addr, ram_we, ram_wdata,
        input  ram_rdata
    );

    modport master (
        output vid_req, vid_addr,
        input  vid_valid, vid_rdata,
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_ack, cpu_rdata,
        output host_req, host_we, host_addr, host_wdata,
        input  host_ack, host_rdata,
        input  ram_addr, ram_we, ram_wdata,
        output ram_rdata
    );

endinterface

// File: rtl/vram_arb_prio.sv
// Fixed-priority grant select (video > CPU > host) with the host starvation counter.
module vram_arb_prio
    import vram_arb_pkg::*;
#(
    parameter int HOST_MAX_WAIT = DEF_HOST_MAX_WAIT,
    parameter int WAIT_W        = cnt_width(HOST_MAX_WAIT)
) (
    input  logic              clk_sys,
    input  logic              nRESET,
    input  logic              vid_req,
    input  logic              cpu_req,
    input  logic              host_req,
    input  logic              cpu_busy,
    input  logic              host_busy,
    output grant_t            grant,
    output logic [WAIT_W-1:0] wait_cnt
);

    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(HOST_MAX_WAIT);

    logic              cpu_elig;
    logic              host_elig;
    logic              host_urgent;
    logic [WAIT_W-1:0] wait_cnt_d;

    assign cpu_elig    = cpu_req  & ~cpu_busy;
    assign host_elig   = host_req & ~host_busy;
    assign host_urgent = (wait_cnt == WAIT_MAX);

    // Host normally only fills slots the CPU leaves empty, unless it has starved.
    always_comb begin
        grant = GNT_NONE;
        if (vid_req) begin
            grant = GNT_VID;
        end else if (host_elig && (host_urgent || !cpu_elig)) begin
            grant = GNT_HOST;
        end else if (cpu_elig) begin
            grant = GNT_CPU;
        end
    end

    always_comb begin
        wait_cnt_d = wait_cnt;
        if (!host_req || grant == GNT_HOST) begin
            wait_cnt_d = '0;
        end else if (grant == GNT_CPU && !host_busy && !host_urgent) begin
            wait_cnt_d = wait_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk_sys or negedge nRESET) begin
        if (!nRESET) begin
            wait_cnt <= '0;
        end else begin
            wait_cnt <= wait_cnt_d;
        end
    end

endmodule

// File: rtl/vram_arbiter.sv
// Single-port screen RAM arbiter: video / CPU / host with a 2-stage grant tag pipeline.
// Optional snow effect is compiled in with the VRAM_ARB_SNOW_EN macro.
module vram_arbiter
    import vram_arb_pkg::*;
#(
    parameter int ADDR_W        = DEF_ADDR_W,
    parameter int DATA_W        = DEF_DATA_W,
    parameter int HOST_MAX_WAIT = DEF_HOST_MAX_WAIT
) (
    input  logic                                 clk_sys,
    input  logic                                 nRESET,
    input  logic                                 snow_ena,
    vram_arbiter_if.slave                        bus,
    output grant_t                               dbg_grant,
    output logic [cnt_width(HOST_MAX_WAIT)-1:0]  dbg_wait_cnt
);

    localparam int WAIT_W = cnt_width(HOST_MAX_WAIT);

    grant_t            grant;
    grant_t            tag_s1;
    grant_t            tag_s2;
    logic              cpu_busy;
    logic              host_busy;
    logic [WAIT_W-1:0] wait_cnt;
    logic [ADDR_W-1:0] vid_addr_eff;
    logic [ADDR_W-1:0] ram_addr_q;
    logic              ram_we_q;
    logic [DATA_W-1:0] ram_wdata_q;

    vram_arb_prio #(
        .HOST_MAX_WAIT (HOST_MAX_WAIT),
        .WAIT_W        (WAIT_W)
    ) u_prio (
        .clk_sys   (clk_sys),
        .nRESET    (nRESET),
        .vid_req   (bus.vid_req),
        .cpu_req   (bus.cpu_req),
        .host_req  (bus.host_req),
        .cpu_busy  (cpu_busy),
        .host_busy (host_busy),
        .grant     (grant),
        .wait_cnt  (wait_cnt)
    );

`ifdef VRAM_ARB_SNOW_EN
    // A losing CPU access in the lower 16 KB corrupts the low video address bits.
    always_comb begin
        vid_addr_eff = bus.vid_addr;
        if (snow_ena && bus.cpu_req && !cpu_busy && (bus.cpu_addr >> 14) == '0) begin
            vid_addr_eff[6:0] = bus.cpu_addr[6:0];
        end
    end
`else
    logic snow_unused;
    assign snow_unused  = snow_ena;
    assign vid_addr_eff = bus.vid_addr;
`endif

    always_ff @(posedge clk_sys or negedge nRESET) begin
        if (!nRESET) begin
            ram_addr_q  <= '0;
            ram_we_q    <= 1'b0;
            ram_wdata_q <= '0;
        end else begin
            ram_we_q <= 1'b0;
            case (grant)
                GNT_VID: begin
                    ram_addr_q <= vid_addr_eff;
                end
                GNT_CPU: begin
                    ram_addr_q  <= bus.cpu_addr;
                    ram_we_q    <= bus.cpu_we;
                    ram_wdata_q <= bus.cpu_wdata;
                end
                GNT_HOST: begin
                    ram_addr_q  <= bus.host_addr;
                    ram_we_q    <= bus.host_we;
                    ram_wdata_q <= bus.host_wdata;
                end
                default: begin
                end
            endcase
        end
    end

    // Tag pipeline; busy flags cover the grant-to-ack window so a held req is not re-granted.
    always_ff @(posedge clk_sys or negedge nRESET) begin
        if (!nRESET) begin
            tag_s1    <= GNT_NONE;
            tag_s2    <= GNT_NONE;
            cpu_busy  <= 1'b0;
            host_busy <= 1'b0;
        end else begin
            tag_s1 <= grant;
            tag_s2 <= tag_s1;
            if (grant == GNT_CPU) begin
                cpu_busy <= 1'b1;
            end else if (tag_s2 == GNT_CPU) begin
                cpu_busy <= 1'b0;
            end
            if (grant == GNT_HOST) begin
                host_busy <= 1'b1;
            end else if (tag_s2 == GNT_HOST) begin
                host_busy <= 1'b0;
            end
        end
    end

    assign bus.ram_addr  = ram_addr_q;
    assign bus.ram_we    = ram_we_q;
    assign bus.ram_wdata = ram_wdata_q;

    // Read data is gated by the tag so idle ports and reset show zero.
    assign bus.vid_valid  = (tag_s2 == GNT_VID);
    assign bus.cpu_ack    = (tag_s2 == GNT_CPU);
    assign bus.host_ack   = (tag_s2 == GNT_HOST);
    assign bus.vid_rdata  = bus.vid_valid ? bus.ram_rdata : '0;
    assign bus.cpu_rdata  = bus.cpu_ack   ? bus.ram_rdata : '0;
    assign bus.host_rdata = bus.host_ack  ? bus.ram_rdata : '0;

    assign dbg_grant    = grant;
    assign dbg_wait_cnt = wait_cnt;

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter with a behavioural 1-cycle-latency screen RAM.
module tb_vram_arbiter;
    import vram_arb_pkg::*;

    localparam int ADDR_W        = 15;
    localparam int DATA_W        = 8;
    localparam int HOST_MAX_WAIT = 8;

    logic       clk_sys = 1'b0;
    logic       nRESET;
    logic       snow_ena;
    grant_t     dbg_grant;
    logic [3:0] dbg_wait_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    vram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    vram_arbiter #(
        .ADDR_W        (ADDR_W),
        .DATA_W        (DATA_W),
        .HOST_MAX_WAIT (HOST_MAX_WAIT)
    ) dut (
        .clk_sys      (clk_sys),
        .nRESET       (nRESET),
        .snow_ena     (snow_ena),
        .bus          (bus),
        .dbg_grant    (dbg_grant),
        .dbg_wait_cnt (dbg_wait_cnt)
    );

    always #5 clk_sys = ~clk_sys;

    // RAM model: unwritten locations read back addr[7:0]; registered read.
    logic [7:0]     mem [0:32767];
    logic [32767:0] written = '0;

    always @(posedge clk_sys) begin
        if (bus.ram_we) begin
            mem[bus.ram_addr]     <= bus.ram_wdata;
            written[bus.ram_addr] <= 1'b1;
        end
        bus.ram_rdata <= written[bus.ram_addr] ? mem[bus.ram_addr] : bus.ram_addr[7:0];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_sys);
        #1;
    endtask

    int cpu_acks;
    int host_ack_cyc;

    initial begin
        nRESET          = 1'b0;
        snow_ena        = 1'b0;
        bus.vid_req     = 1'b0;
        bus.vid_addr    = '0;
        bus.cpu_req     = 1'b0;
        bus.cpu_we      = 1'b0;
        bus.cpu_addr    = '0;
        bus.cpu_wdata   = '0;
        bus.host_req    = 1'b0;
        bus.host_we     = 1'b0;
        bus.host_addr   = '0;
        bus.host_wdata  = '0;

        // Reset state
        step();
        step();
        check("rst_vid_valid", 32'(bus.vid_valid), 0);
        check("rst_cpu_ack",   32'(bus.cpu_ack),   0);
        check("rst_host_ack",  32'(bus.host_ack),  0);
        check("rst_ram_we",    32'(bus.ram_we),    0);
        check("rst_ram_addr",  32'(bus.ram_addr),  0);
        check("rst_ram_wdata", 32'(bus.ram_wdata), 0);
        check("rst_vid_rdata", 32'(bus.vid_rdata), 0);
        check("rst_wait_cnt",  32'(dbg_wait_cnt),  0);
        nRESET = 1'b1;
        step();

        // Video burst: 16 back-to-back reads, data appears 2 cycles later in order
        for (int j = 0; j < 18; j++) begin
            if (j < 16) begin
                bus.vid_req  = 1'b1;
                bus.vid_addr = ADDR_W'(j);
            end else begin
                bus.vid_req = 1'b0;
            end
            if (j >= 2) begin
                check("burst_valid", 32'(bus.vid_valid), 1);
                check("burst_data",  32'(bus.vid_rdata), 32'(j - 2));
            end else begin
                check("burst_early_valid", 32'(bus.vid_valid), 0);
            end
            step();
        end
        check("burst_end_valid", 32'(bus.vid_valid), 0);

        // CPU write 0x5A to 0x1234
        bus.cpu_req   = 1'b1;
        bus.cpu_we    = 1'b1;
        bus.cpu_addr  = 15'h1234;
        bus.cpu_wdata = 8'h5A;
        step();
        check("wr_ram_addr",  32'(bus.ram_addr),  32'h1234);
        check("wr_ram_we",    32'(bus.ram_we),    1);
        check("wr_ram_wdata", 32'(bus.ram_wdata), 32'h5A);
        check("wr_ack_early", 32'(bus.cpu_ack),   0);
        step();
        check("wr_ack", 32'(bus.cpu_ack), 1);
        step();
        bus.cpu_req = 1'b0;
        check("wr_ack_gone",    32'(bus.cpu_ack),  0);
        check("idle_ram_we",    32'(bus.ram_we),   0);
        check("idle_addr_hold", 32'(bus.ram_addr), 32'h1234);
        step();

        // CPU read back
        bus.cpu_req = 1'b1;
        bus.cpu_we  = 1'b0;
        step();
        check("rd_ack_early", 32'(bus.cpu_ack), 0);
        check("rd_ram_we",    32'(bus.ram_we),  0);
        step();
        check("rd_ack",   32'(bus.cpu_ack),   1);
        check("rd_rdata", 32'(bus.cpu_rdata), 32'h5A);
        step();
        bus.cpu_req = 1'b0;
        check("rd_ack_gone",  32'(bus.cpu_ack),   0);
        check("rd_rdata_idle", 32'(bus.cpu_rdata), 0);
        step();

        // All three request together: VID, CPU, HOST on consecutive cycles
        bus.vid_req   = 1'b1;
        bus.vid_addr  = 15'h0010;
        bus.cpu_req   = 1'b1;
        bus.cpu_we    = 1'b0;
        bus.cpu_addr  = 15'h0020;
        bus.host_req  = 1'b1;
        bus.host_we   = 1'b0;
        bus.host_addr = 15'h0030;
        #1;
        check("tri_grant0", 32'(dbg_grant), 32'(GNT_VID));
        step();
        bus.vid_req = 1'b0;
        #1;
        check("tri_grant1",  32'(dbg_grant),   32'(GNT_CPU));
        check("tri_addr_v",  32'(bus.ram_addr), 32'h0010);
        step();
        #1;
        check("tri_grant2",  32'(dbg_grant),   32'(GNT_HOST));
        check("tri_addr_c",  32'(bus.ram_addr), 32'h0020);
        check("tri_vvalid",  32'(bus.vid_valid), 1);
        check("tri_vdata",   32'(bus.vid_rdata), 32'h10);
        check("tri_cack_n2", 32'(bus.cpu_ack),   0);
        check("tri_hack_n2", 32'(bus.host_ack),  0);
        step();
        check("tri_addr_h",  32'(bus.ram_addr),  32'h0030);
        check("tri_cack",    32'(bus.cpu_ack),   1);
        check("tri_cdata",   32'(bus.cpu_rdata), 32'h20);
        check("tri_vv_n3",   32'(bus.vid_valid), 0);
        check("tri_hack_n3", 32'(bus.host_ack),  0);
        step();
        bus.cpu_req = 1'b0;
        check("tri_hack",    32'(bus.host_ack),   1);
        check("tri_hdata",   32'(bus.host_rdata), 32'h30);
        check("tri_cack_n4", 32'(bus.cpu_ack),    0);
        step();
        bus.host_req = 1'b0;
        check("tri_hack_gone", 32'(bus.host_ack), 0);
        step();

        // Starvation guard: video fills the CPU's busy cycles, host waits 8 CPU grants
        bus.cpu_req   = 1'b1;
        bus.cpu_we    = 1'b0;
        bus.cpu_addr  = 15'h0050;
        bus.host_req  = 1'b1;
        bus.host_we   = 1'b0;
        bus.host_addr = 15'h0060;
        bus.vid_addr  = 15'h0070;
        cpu_acks      = 0;
        host_ack_cyc  = -1;
        for (int c = 0; c < 27; c++) begin
            bus.vid_req = ((c % 3) != 0);
            if (bus.cpu_ack) cpu_acks++;
            if (bus.host_ack && host_ack_cyc < 0) host_ack_cyc = c;
            if (c == 24) check("starve_wait_max", 32'(dbg_wait_cnt), 8);
            if (c == 25) check("starve_wait_clr", 32'(dbg_wait_cnt), 0);
            step();
        end
        bus.vid_req  = 1'b0;
        bus.cpu_req  = 1'b0;
        bus.host_req = 1'b0;
        check("starve_cpu_acks", 32'(cpu_acks),     8);
        check("starve_host_ack", 32'(host_ack_cyc), 26);
        step();
        step();
        step();

        // Reset one cycle after a CPU grant drops the access
        bus.cpu_req  = 1'b1;
        bus.cpu_we   = 1'b0;
        bus.cpu_addr = 15'h0040;
        step();
        nRESET      = 1'b0;
        bus.cpu_req = 1'b0;
        #1;
        check("mid_rst_ram_addr", 32'(bus.ram_addr),  0);
        check("mid_rst_ram_we",   32'(bus.ram_we),    0);
        check("mid_rst_cpu_ack",  32'(bus.cpu_ack),   0);
        check("mid_rst_vvalid",   32'(bus.vid_valid), 0);
        check("mid_rst_cdata",    32'(bus.cpu_rdata), 0);
        step();
        check("mid_rst_ack_slot", 32'(bus.cpu_ack),  0);
        check("mid_rst_addr2",    32'(bus.ram_addr), 0);
        nRESET = 1'b1;
        step();
        check("post_rst_ack1", 32'(bus.cpu_ack), 0);
        step();
        check("post_rst_ack2", 32'(bus.cpu_ack), 0);
        bus.cpu_req = 1'b1;
        step();
        step();
        check("post_rst_ack",   32'(bus.cpu_ack),   1);
        check("post_rst_rdata", 32'(bus.cpu_rdata), 32'h40);
        step();
        bus.cpu_req = 1'b0;
        step();

        // Snow collision: video 0x0100 vs CPU 0x0035
        snow_ena     = 1'b1;
        bus.vid_req  = 1'b1;
        bus.vid_addr = 15'h0100;
        bus.cpu_req  = 1'b1;
        bus.cpu_we   = 1'b0;
        bus.cpu_addr = 15'h0035;
        step();
        bus.vid_req = 1'b0;
`ifdef VRAM_ARB_SNOW_EN
        check("snow_ram_addr", 32'(bus.ram_addr), 32'h0135);
`else
        check("snow_ram_addr", 32'(bus.ram_addr), 32'h0100);
`endif
        step();
        check("snow_cpu_addr", 32'(bus.ram_addr),  32'h0035);
        check("snow_vvalid",   32'(bus.vid_valid), 1);
`ifdef VRAM_ARB_SNOW_EN
        check("snow_vdata", 32'(bus.vid_rdata), 32'h35);
`else
        check("snow_vdata", 32'(bus.vid_rdata), 32'h00);
`endif
        step();
        check("snow_cack",  32'(bus.cpu_ack),   1);
        check("snow_cdata", 32'(bus.cpu_rdata), 32'h35);
        step();
        bus.cpu_req = 1'b0;
        snow_ena    = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
